// File: rtl/uart_cmd_frame_parser.sv
// uart_cmd_frame_parser: HEAD|CMD|body|TAIL frame decoder with payload buffer.
// Build option FRAME_CHKSUM_EN adds an XOR checksum byte ahead of the tail.
module uart_cmd_frame_parser #(
    parameter int MAX_LEN     = 16,
    parameter int BLK_W       = 2,
    parameter int TIMEOUT_CYC = 50000,
    localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       din,
    input  logic             din_vld,
    output logic             cmd_vld,
    input  logic             cmd_rdy,
    output logic [1:0]       cmd_op,
    output logic [BLK_W-1:0] cmd_blk,
    output logic [7:0]       cmd_addr,
    output logic [LEN_W-1:0] cmd_len,
    input  logic             pl_rd,
    output logic [7:0]       pl_dout,
    output logic             pl_empty,
    output logic             err_vld,
    output logic [2:0]       err_code
);

`ifdef FRAME_CHKSUM_EN
    localparam int BUF_N = MAX_LEN + 1;
`else
    localparam int BUF_N = MAX_LEN;
`endif
    localparam int CNT_W = $clog2(BUF_N + 1);
    localparam int IDX_W = (BUF_N > 1) ? $clog2(BUF_N) : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int NBLK  = 1 << BLK_W;

    localparam logic [7:0] HEAD   = 8'h55;
    localparam logic [7:0] CMD_DL = 8'hAA;
    localparam logic [7:0] TL1    = 8'h04;
    localparam logic [7:0] TL2    = 8'h0D;

    localparam logic [1:0] OP_DL = 2'd0;
    localparam logic [1:0] OP_WR = 2'd1;
    localparam logic [1:0] OP_RD = 2'd2;

    localparam logic [2:0] E_CMD  = 3'd1;
    localparam logic [2:0] E_TAIL = 3'd2;
    localparam logic [2:0] E_OVF  = 3'd3;
    localparam logic [2:0] E_TMO  = 3'd4;
    localparam logic [2:0] E_OVR  = 3'd6;
`ifdef FRAME_CHKSUM_EN
    localparam logic [2:0] E_CHK  = 3'd5;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_CHK,
        S_TAIL1, S_TAIL2, S_DATA, S_ESC
    } state_t;

    state_t           state, nxt;
    logic [CNT_W-1:0] wr_cnt;
    logic [TO_W-1:0]  tmo_cnt;
    logic [1:0]       op_q;
    logic [BLK_W-1:0] blk_q;
    logic [7:0]       addr_q;
    logic [LEN_W-1:0] com_len;
    logic [LEN_W-1:0] rd_idx;
    logic [LEN_W-1:0] commit_len;
    logic [7:0]       buf_q [BUF_N];

    logic             err_ev;
    logic [2:0]       err_c;
    logic [1:0]       st_n;
    logic [7:0]       wd0;
    logic             fin;
    logic             dl_start;
    logic             op_we;
    logic [1:0]       op_n;
    logic [BLK_W-1:0] blk_n;
    logic             addr_we;
    logic             blk_ok, is_dl, is_wr, is_rd;

`ifdef FRAME_CHKSUM_EN
    logic [7:0]       chk_acc, acc_n;
    assign commit_len = LEN_W'(wr_cnt - CNT_W'(1));
`else
    assign commit_len = LEN_W'(wr_cnt);
`endif

    assign blk_ok   = int'(din[3:0]) < NBLK;
    assign is_dl    = din == CMD_DL;
    assign is_wr    = din[7:4] == 4'h0 && blk_ok;
    assign is_rd    = din[7:4] == 4'h1 && blk_ok;
    assign pl_dout  = buf_q[IDX_W'(rd_idx)];
    assign pl_empty = rd_idx == com_len;

    // Frame FSM next state, buffer stores and error detection
    always_comb begin
        nxt      = state;
        err_ev   = 1'b0;
        err_c    = 3'd0;
        st_n     = 2'd0;
        wd0      = din;
        fin      = 1'b0;
        dl_start = 1'b0;
        op_we    = 1'b0;
        op_n     = OP_DL;
        blk_n    = '0;
        addr_we  = 1'b0;
`ifdef FRAME_CHKSUM_EN
        acc_n    = chk_acc;
`endif
        if (din_vld) begin
            unique case (state)
                S_IDLE: if (din == HEAD) nxt = S_CMD;
                S_CMD: begin
                    unique case (1'b1)
                        is_dl: begin
                            nxt      = S_DATA;
                            dl_start = 1'b1;
                            op_we    = 1'b1;
                        end
                        is_wr: begin
                            nxt   = S_ADDR;
                            op_we = 1'b1;
                            op_n  = OP_WR;
                            blk_n = din[BLK_W-1:0];
                        end
                        is_rd: begin
                            nxt   = S_ADDR;
                            op_we = 1'b1;
                            op_n  = OP_RD;
                            blk_n = din[BLK_W-1:0];
                        end
                        default: begin
                            err_ev = 1'b1;
                            err_c  = E_CMD;
                        end
                    endcase
                end
                S_ADDR: begin
                    addr_we = 1'b1;
`ifdef FRAME_CHKSUM_EN
                    nxt     = S_CHK;
`else
                    nxt     = S_TAIL1;
`endif
                end
                S_CHK: nxt = S_TAIL1;
                S_TAIL1: begin
                    if (din == TL1) begin
                        nxt = S_TAIL2;
                    end else begin
                        err_ev = 1'b1;
                        err_c  = E_TAIL;
                    end
                end
                S_TAIL2: begin
                    if (din == TL2) begin
                        nxt = S_IDLE;
                        fin = 1'b1;
                    end else begin
                        err_ev = 1'b1;
                        err_c  = E_TAIL;
                    end
                end
                S_DATA: begin
                    if (din == TL1) begin
                        nxt = S_ESC;
                    end else begin
                        st_n = 2'd1;
                    end
                end
                S_ESC: begin
                    // a 0x04 not followed by 0x0D was payload after all
                    wd0 = TL1;
                    if (din == TL2) begin
                        nxt = S_IDLE;
                        fin = 1'b1;
                    end else if (din == TL1) begin
                        st_n = 2'd1;
                    end else begin
                        st_n = 2'd2;
                        nxt  = S_DATA;
                    end
                end
                default: nxt = S_IDLE;
            endcase
`ifdef FRAME_CHKSUM_EN
            if (state == S_CMD) acc_n = din;
            if (state == S_ADDR || state == S_CHK) acc_n = chk_acc ^ din;
            if (st_n != 2'd0) acc_n = acc_n ^ wd0;
            if (st_n == 2'd2) acc_n = acc_n ^ din;
`endif
            if (int'(wr_cnt) + int'(st_n) > BUF_N) begin
                err_ev = 1'b1;
                err_c  = E_OVF;
            end
            if (fin && cmd_vld) begin
                err_ev = 1'b1;
                err_c  = E_OVR;
            end
`ifdef FRAME_CHKSUM_EN
            if (fin && acc_n != 8'h00) begin
                err_ev = 1'b1;
                err_c  = E_CHK;
            end
`endif
        end else if (state != S_IDLE && tmo_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            err_ev = 1'b1;
            err_c  = E_TMO;
        end
        if (err_ev) begin
            nxt  = S_IDLE;
            st_n = 2'd0;
            fin  = 1'b0;
        end
    end

    // State register, inter-byte timer and staged command fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            wr_cnt  <= '0;
            tmo_cnt <= '0;
            op_q    <= OP_DL;
            blk_q   <= '0;
            addr_q  <= '0;
        end else begin
            state   <= nxt;
            tmo_cnt <= (din_vld || state == S_IDLE) ? '0 : tmo_cnt + TO_W'(1);
            if (err_ev || dl_start) begin
                wr_cnt <= '0;
            end else begin
                wr_cnt <= wr_cnt + CNT_W'(st_n);
            end
            if (op_we) begin
                op_q   <= op_n;
                blk_q  <= blk_n;
                addr_q <= '0;
            end
            if (addr_we) addr_q <= din;
        end
    end

`ifdef FRAME_CHKSUM_EN
    // Running XOR over CMD..checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chk_acc <= '0;
        else        chk_acc <= acc_n;
    end
`endif

    // Payload storage, up to two bytes per strobe when an escape resolves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_N; i++) buf_q[i] <= '0;
        end else begin
            if (st_n != 2'd0) buf_q[IDX_W'(wr_cnt)] <= wd0;
            if (st_n == 2'd2) buf_q[IDX_W'(wr_cnt + CNT_W'(1))] <= din;
        end
    end

    // Committed length and read pointer; commit beats a same-cycle pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            com_len <= '0;
            rd_idx  <= '0;
        end else if (dl_start) begin
            com_len <= '0;
            rd_idx  <= '0;
        end else if (fin && op_q == OP_DL) begin
            com_len <= commit_len;
            rd_idx  <= '0;
        end else if (pl_rd && !pl_empty) begin
            rd_idx  <= rd_idx + LEN_W'(1);
        end
    end

    // Command output holding register and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_vld  <= 1'b0;
            cmd_op   <= '0;
            cmd_blk  <= '0;
            cmd_addr <= '0;
            cmd_len  <= '0;
        end else if (fin) begin
            cmd_vld  <= 1'b1;
            cmd_op   <= op_q;
            cmd_blk  <= blk_q;
            cmd_addr <= addr_q;
            cmd_len  <= (op_q == OP_DL) ? commit_len : '0;
        end else if (cmd_vld && cmd_rdy) begin
            cmd_vld  <= 1'b0;
            cmd_op   <= '0;
            cmd_blk  <= '0;
            cmd_addr <= '0;
            cmd_len  <= '0;
        end
    end

    // Error pulse; code holds its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vld  <= 1'b0;
            err_code <= '0;
        end else begin
            err_vld <= err_ev;
            if (err_ev) err_code <= err_c;
        end
    end

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// tb_uart_cmd_frame_parser: directed frames against a frame-level model.
// Default build (no checksum byte); short timeout for quick runs.
module tb_uart_cmd_frame_parser;

    localparam int ML  = 16;
    localparam int BW  = 2;
    localparam int TMO = 40;
    localparam int LW  = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    din = '0;
    logic          din_vld = 1'b0;
    logic          cmd_rdy = 1'b0;
    logic          pl_rd = 1'b0;
    logic          cmd_vld;
    logic [1:0]    cmd_op;
    logic [BW-1:0] cmd_blk;
    logic [7:0]    cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [7:0]    pl_dout;
    logic          pl_empty;
    logic          err_vld;
    logic [2:0]    err_code;

    uart_cmd_frame_parser #(
        .MAX_LEN(ML), .BLK_W(BW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
        .cmd_blk(cmd_blk), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .pl_rd(pl_rd), .pl_dout(pl_dout), .pl_empty(pl_empty),
        .err_vld(err_vld), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    bit           m_vld, m_err, m_in, old_vld;
    int           m_op, m_blk, m_addr, m_clen, m_len, m_rd, m_code, m_idle, st;
    byte unsigned m_pl[$];
    byte unsigned m_fq[$];

    // 0 = frame still open, 8 = complete, else the error code it earns
    function automatic int frame_status();
        int n = m_fq.size();
        byte unsigned c = m_fq[0];
        int b, stored;
        if (c == 8'hAA) begin
            b = n - 1;
            if (b >= 2 && m_fq[n-2] == 8'h04 && m_fq[n-1] == 8'h0D) return 8;
            stored = (b >= 1 && m_fq[n-1] == 8'h04) ? b - 1 : b;
            return (stored > ML) ? 3 : 0;
        end
        if (c[7:4] > 4'd1 || int'(c[3:0]) >= (1 << BW)) return 1;
        if (n == 3 && m_fq[2] != 8'h04) return 2;
        if (n == 4) return (m_fq[3] == 8'h0D) ? 8 : 2;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld = 0; m_err = 0; m_in = 0;
            m_op = 0; m_blk = 0; m_addr = 0; m_clen = 0;
            m_len = 0; m_rd = 0; m_code = 0; m_idle = 0;
            m_pl.delete(); m_fq.delete();
        end else begin
            old_vld = m_vld;
            m_err = 0;
            if (m_vld && cmd_rdy) begin
                m_vld = 0; m_op = 0; m_blk = 0; m_addr = 0; m_clen = 0;
            end
            if (pl_rd && m_rd < m_len) m_rd++;
            if (din_vld) begin
                m_idle = 0;
                if (!m_in) begin
                    if (din == 8'h55) begin
                        m_in = 1;
                        m_fq.delete();
                    end
                end else begin
                    m_fq.push_back(din);
                    if (m_fq.size() == 1 && din == 8'hAA) begin
                        m_len = 0; m_rd = 0; m_pl.delete();
                    end
                    st = frame_status();
                    if (st == 8) begin
                        m_in = 0;
                        if (old_vld) begin
                            m_err = 1; m_code = 6;
                        end else begin
                            m_vld = 1;
                            if (m_fq[0] == 8'hAA) begin
                                m_op = 0; m_blk = 0; m_addr = 0;
                                m_pl.delete();
                                for (int i = 1; i < m_fq.size() - 2; i++)
                                    m_pl.push_back(m_fq[i]);
                                m_len = m_pl.size();
                                m_clen = m_len;
                                m_rd = 0;
                            end else begin
                                m_op = (m_fq[0] >= 8'h10) ? 2 : 1;
                                m_blk = m_fq[0] & 8'h0F;
                                m_addr = m_fq[1];
                                m_clen = 0;
                            end
                        end
                    end else if (st != 0) begin
                        m_in = 0; m_err = 1; m_code = st;
                    end
                end
            end else if (m_in) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_in = 0; m_err = 1; m_code = 4;
                end
            end
        end
    end

    // compare every cycle, mid-period
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmd_vld", cmd_vld, m_vld);
            chk("cmd_op", cmd_op, m_op);
            chk("cmd_blk", cmd_blk, m_blk);
            chk("cmd_addr", cmd_addr, m_addr);
            chk("cmd_len", cmd_len, m_clen);
            chk("err_vld", err_vld, m_err);
            if (m_err) chk("err_code", err_code, m_code);
            chk("pl_empty", pl_empty, m_rd == m_len);
            if (m_rd < m_len) chk("pl_dout", pl_dout, m_pl[m_rd]);
        end
    end

    // ---------------- stimulus ----------------
    byte unsigned fr[$];

    task automatic send(input logic [7:0] b);
        din = b; din_vld = 1'b1;
        @(posedge clk); #1;
        din_vld = 1'b0;
    endtask

    task automatic send_fr();
        foreach (fr[i]) send(fr[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic accept();
        cmd_rdy = 1'b1;
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
        chk("cmd_clr", cmd_vld, 0);
    endtask

    task automatic wait_cmd(input int op, input int blk, input int addr,
                            input int len, input bit acc);
        int i = 0;
        while (!cmd_vld && i < 20) begin @(posedge clk); #1; i++; end
        chk("cmd_seen", cmd_vld, 1);
        chk("cmd_lat", i, 0);
        if (cmd_vld) begin
            chk("lit_op", cmd_op, op);
            chk("lit_blk", cmd_blk, blk);
            chk("lit_addr", cmd_addr, addr);
            chk("lit_len", cmd_len, len);
        end
        if (acc) accept();
    endtask

    task automatic wait_err(input int code, input int bound, input int lat);
        int i = 0;
        while (!err_vld && i < bound) begin @(posedge clk); #1; i++; end
        chk("err_seen", err_vld, 1);
        chk("err_lat", i, lat);
        if (err_vld) chk("lit_err", err_code, code);
        @(posedge clk); #1;
        chk("err_pulse", err_vld, 0);
    endtask

    task automatic pop_chk(input logic [7:0] exp);
        chk("pop_nonempty", pl_empty, 0);
        chk("pop_byte", pl_dout, exp);
        pl_rd = 1'b1;
        @(posedge clk); #1;
        pl_rd = 1'b0;
    endtask

    byte unsigned exp_pl[$];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_vld", cmd_vld, 0);
        chk("rst_err_vld", err_vld, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_pl_empty", pl_empty, 1);
        chk("rst_cmd_op", cmd_op, 0);
        chk("rst_cmd_len", cmd_len, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        rst_n = 1'b1;
        idle(2);

        // junk while idle: no error, no command
        send(8'h12); send(8'h34); send(8'h04); send(8'h0D);
        idle(3);

        // long data load with embedded 0x55
        fr = '{8'h55, 8'hAA, 8'h55, 8'h35, 8'h55, 8'h67, 8'hFE, 8'h8C,
               8'hA2, 8'hB7, 8'hA9, 8'hD0, 8'h53, 8'h04, 8'h0D};
        send_fr();
        wait_cmd(0, 0, 0, 11, 1'b0);
        exp_pl = '{8'h55, 8'h35, 8'h55, 8'h67, 8'hFE, 8'h8C,
                   8'hA2, 8'hB7, 8'hA9, 8'hD0, 8'h53};
        foreach (exp_pl[i]) pop_chk(exp_pl[i]);
        chk("drained", pl_empty, 1);
        pl_rd = 1'b1; @(posedge clk); #1; pl_rd = 1'b0;
        chk("pop_empty_ignored", pl_empty, 1);
        accept();

        // write then read request
        fr = '{8'h55, 8'h00, 8'hA3, 8'h04, 8'h0D};
        send_fr();
        wait_cmd(1, 0, 8'hA3, 0, 1'b1);
        fr = '{8'h55, 8'h10, 8'hA3, 8'h04, 8'h0D};
        send_fr();
        wait_cmd(2, 0, 8'hA3, 0, 1'b1);
        fr = '{8'h55, 8'h13, 8'h7F, 8'h04, 8'h0D};
        send_fr();
        wait_cmd(2, 3, 8'h7F, 0, 1'b1);

        // embedded 0x04 and double escape
        fr = '{8'h55, 8'hAA, 8'h11, 8'h04, 8'h22, 8'h04, 8'h0D};
        send_fr();
        wait_cmd(0, 0, 0, 3, 1'b0);
        pop_chk(8'h11); pop_chk(8'h04); pop_chk(8'h22);
        accept();
        fr = '{8'h55, 8'hAA, 8'h04, 8'h04, 8'h0D};
        send_fr();
        wait_cmd(0, 0, 0, 1, 1'b0);
        pop_chk(8'h04);
        accept();
        fr = '{8'h55, 8'hAA, 8'h04, 8'h0D};
        send_fr();
        wait_cmd(0, 0, 0, 0, 1'b1);
        chk("empty_frame", pl_empty, 1);

        // exactly MAX_LEN bytes fits
        send(8'h55); send(8'hAA);
        for (int i = 0; i < ML; i++) send(8'(i));
        send(8'h04); send(8'h0D);
        wait_cmd(0, 0, 0, ML, 1'b1);
        // one more overflows on the 17th byte
        send(8'h55); send(8'hAA);
        for (int i = 0; i < ML + 1; i++) send(8'(8'h10 + i));
        wait_err(3, 5, 0);
        chk("ovf_empty", pl_empty, 1);
        // escape resolving into the 17th byte overflows
        send(8'h55); send(8'hAA);
        for (int i = 0; i < ML - 1; i++) send(8'(8'h30 + i));
        send(8'h04); send(8'h99);
        wait_err(3, 5, 0);
        // escaped 0x04 as the 16th byte still fits
        send(8'h55); send(8'hAA);
        for (int i = 0; i < ML - 1; i++) send(8'(8'h40 + i));
        send(8'h04); send(8'h04); send(8'h0D);
        wait_cmd(0, 0, 0, ML, 1'b1);
        fr = '{8'h55, 8'h00, 8'hA3, 8'h04, 8'h0D};
        send_fr();
        wait_cmd(1, 0, 8'hA3, 0, 1'b1);

        // timeout exactly TMO idle cycles after last byte
        send(8'h55); send(8'h00);
        wait_err(4, TMO + 10, TMO);
        chk("tmo_no_cmd", cmd_vld, 0);
        // one cycle short of timeout survives
        send(8'h55); send(8'h01);
        idle(TMO - 1);
        send(8'hB4); send(8'h04); send(8'h0D);
        wait_cmd(1, 1, 8'hB4, 0, 1'b1);

        // bad commands and bad tails
        send(8'h55); send(8'h30);
        wait_err(1, 5, 0);
        send(8'h55); send(8'h04);
        wait_err(1, 5, 0);
        fr = '{8'h55, 8'h00, 8'hA3, 8'h04, 8'h0A};
        send_fr();
        wait_err(2, 5, 0);
        fr = '{8'h55, 8'h00, 8'hA3, 8'h05};
        send_fr();
        wait_err(2, 5, 0);

        // overrun while a command is pending
        fr = '{8'h55, 8'h00, 8'h11, 8'h04, 8'h0D};
        send_fr();
        idle(2);
        fr = '{8'h55, 8'h10, 8'h22, 8'h04, 8'h0D};
        send_fr();
        wait_err(6, 5, 0);
        wait_cmd(1, 0, 8'h11, 0, 1'b1);

        // pop asserted on the committing cycle
        fr = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h04};
        send_fr();
        pl_rd = 1'b1;
        send(8'h0D);
        pl_rd = 1'b0;
        wait_cmd(0, 0, 0, 2, 1'b1);
        pop_chk(8'h01); pop_chk(8'h02);
        chk("final_empty", pl_empty, 1);

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
